spi_cmd_arbiter: RTL and testbench

- Shares the single SPI master among NREQ requesters (CPU bridge, boot loader, test port).
- Round-robin picks one requester's instruction word and presents it on the master's command interface (master_en / driver_data / driver_read).
- Waits for transfer completion, then routes read-back data and address to the winning requester.
- Exactly one transaction is outstanding at a time.

---
 rtl/spi_pkg.sv | 35 +++
 rtl/spi_cmd_arbiter_rr_arbiter.sv | 36 +++
 rtl/spi_cmd_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_spi_cmd_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared widths, command layout and FSM state type for the SPI command arbiter.
package spi_pkg;

   localparam int SPI_AWIDTH = 8;
   localparam int SPI_DWIDTH = 16;
   localparam int SPI_CMD_W  = SPI_DWIDTH + SPI_AWIDTH + 5;

   // Bit offsets of the command fields, LSB first: {ss, wdata, addr, size, wr_en}
   localparam int CMD_WR_EN_LSB = 0;
   localparam int CMD_SIZE_LSB  = 1;
   localparam int CMD_ADDR_LSB  = 3;
   localparam int CMD_WDATA_LSB = CMD_ADDR_LSB + SPI_AWIDTH;
   localparam int CMD_SS_LSB    = CMD_WDATA_LSB + SPI_DWIDTH;

   typedef struct packed {
      logic [1:0]            ss;
      logic [SPI_DWIDTH-1:0] wdata;
      logic [SPI_AWIDTH-1:0] addr;
      logic [1:0]            size;
      logic                  wr_en;
   } spi_cmd_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   // Command word width for a given address/data width.
   function automatic int cmd_width(input int aw, input int dw);
      return dw + aw + 5;
   endfunction

endpackage

// File: rtl/spi_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rr_arbiter
   import spi_pkg::*;
#(
   parameter  int NREQ = 3,
   localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [GW-1:0]   last_grant,
   output logic [NREQ-1:0] gnt,
   output logic [GW-1:0]   gnt_idx,
   output logic            gnt_any
);

   // Scan offsets 1..NREQ from the previous winner; the previous winner is
   // tried last, so it can only win again when nobody else is asking.
   always_comb begin
      int cand;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = 0;
      for (int off = 1; off <= NREQ; off++) begin
         cand = int'(last_grant) + off;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (!gnt_any && req[cand[GW-1:0]]) begin
            gnt_any               = 1'b1;
            gnt_idx               = cand[GW-1:0];
            gnt[cand[GW-1:0]]     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Shares one SPI master among NREQ requesters, one transaction at a time.
// Optional watchdog: define SPI_TIMEOUT_EN to abort transactions that stall
// for TIMEOUT_CYC cycles (response returned with rsp_err=1, rsp_data=0).
//
// state | meaning
// IDLE  | no transaction; round-robin grant and latch of the winner's command
// ISSUE | master_en high, driver_data stable until the master reads it
// WAIT  | command taken by the master, waiting for xfer_done
// RESP  | one-cycle rsp_valid pulse to the granted requester
module spi_cmd_arbiter
   import spi_pkg::*;
#(
   parameter  int NREQ        = 3,
   parameter  int AWIDTH      = SPI_AWIDTH,
   parameter  int DWIDTH      = SPI_DWIDTH,
   parameter  int TIMEOUT_CYC = 4096,
   localparam int CMD_W       = cmd_width(AWIDTH, DWIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*CMD_W-1:0] req_cmd,
   output logic [NREQ-1:0]       req_ready,
   output logic                  master_en,
   output logic [CMD_W-1:0]      driver_data,
   input  logic                  driver_read,
   input  logic                  xfer_done,
   input  logic [AWIDTH-1:0]     spi_slv_addr,
   input  logic [DWIDTH-1:0]     spi_slv_data,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [AWIDTH-1:0]     rsp_addr,
   output logic [DWIDTH-1:0]     rsp_data,
   output logic                  rsp_err
);

   localparam int            GW         = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [GW-1:0] LAST_RESET = GW'(NREQ - 1);

   if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 2) begin : g_param_chk
      $error("spi_cmd_arbiter: NREQ must be 2..8 and TIMEOUT_CYC >= 2");
   end

   arb_state_e        state_q, state_d;
   logic [CMD_W-1:0]  cmd_q, cmd_d;
   logic [GW-1:0]     grant_q, grant_d;
   logic [GW-1:0]     last_grant_q, last_grant_d;
   logic [AWIDTH-1:0] rsp_addr_q, rsp_addr_d;
   logic [DWIDTH-1:0] rsp_data_q, rsp_data_d;

   logic [NREQ-1:0]   arb_gnt;
   logic [GW-1:0]     arb_idx;
   logic              arb_any;

   rr_arbiter #(
      .NREQ       (NREQ)
   ) u_rr_arbiter (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .gnt        (arb_gnt),
      .gnt_idx    (arb_idx),
      .gnt_any    (arb_any)
   );

`ifdef SPI_TIMEOUT_EN
   localparam int            TW      = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [TW-1:0] TMO_TC  = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          err_q, err_d;
   logic          tmo_hit;

   assign tmo_hit = (tmo_cnt_q == TMO_TC);

   // Watchdog counts cycles spent in ISSUE/WAIT; zero whenever idle so it
   // starts from zero on entry to ISSUE.
   always_comb begin
      tmo_cnt_d = '0;
      if (state_q == ISSUE || state_q == WAIT) begin
         tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
   end

   // Watchdog counter and error flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         err_q     <= err_d;
      end
   end

   assign rsp_err = (state_q == RESP) && err_q;
`else
   assign rsp_err = 1'b0;
`endif

   // Next-state and output decode for the transaction FSM.
   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      rsp_addr_d   = rsp_addr_q;
      rsp_data_d   = rsp_data_q;
      req_ready    = '0;
      master_en    = 1'b0;
      rsp_valid    = '0;
`ifdef SPI_TIMEOUT_EN
      err_d        = err_q;
`endif
      unique case (state_q)
         IDLE: begin
`ifdef SPI_TIMEOUT_EN
            err_d = 1'b0;
`endif
            // Grant is suppressed while reset is held so every output reads 0.
            if (arb_any && !rst) begin
               req_ready = arb_gnt;
               cmd_d     = req_cmd[arb_idx*CMD_W +: CMD_W];
               grant_d   = arb_idx;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            master_en = 1'b1;
            if (driver_read) begin
               if (xfer_done) begin
                  rsp_addr_d = spi_slv_addr;
                  rsp_data_d = spi_slv_data;
                  state_d    = RESP;
               end else begin
                  state_d    = WAIT;
               end
            end
`ifdef SPI_TIMEOUT_EN
            else if (tmo_hit) begin
               rsp_data_d = '0;
               err_d      = 1'b1;
               state_d    = RESP;
            end
`endif
         end
         WAIT: begin
            if (xfer_done) begin
               rsp_addr_d = spi_slv_addr;
               rsp_data_d = spi_slv_data;
               state_d    = RESP;
            end
`ifdef SPI_TIMEOUT_EN
            else if (tmo_hit) begin
               rsp_data_d = '0;
               err_d      = 1'b1;
               state_d    = RESP;
            end
`endif
         end
         RESP: begin
            rsp_valid[grant_q] = 1'b1;
            last_grant_d       = grant_q;
            state_d            = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, command and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cmd_q        <= '0;
         grant_q      <= '0;
         last_grant_q <= LAST_RESET;
         rsp_addr_q   <= '0;
         rsp_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         rsp_addr_q   <= rsp_addr_d;
         rsp_data_q   <= rsp_data_d;
      end
   end

   assign driver_data = cmd_q;
   assign rsp_addr    = rsp_addr_q;
   assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Self-checking bench for spi_cmd_arbiter against a transaction-level model.
module tb_spi_cmd_arbiter;
   import spi_pkg::*;

   localparam int NREQ  = 3;
   localparam int AW    = SPI_AWIDTH;
   localparam int DW    = SPI_DWIDTH;
   localparam int CMD_W = SPI_CMD_W;
`ifdef SPI_TIMEOUT_EN
   localparam int TCYC  = 32;
`else
   localparam int TCYC  = 4096;
`endif

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*CMD_W-1:0] req_cmd;
   logic [NREQ-1:0]       req_ready;
   logic                  master_en;
   logic [CMD_W-1:0]      driver_data;
   logic                  driver_read;
   logic                  xfer_done;
   logic [AW-1:0]         spi_slv_addr;
   logic [DW-1:0]         spi_slv_data;
   logic [NREQ-1:0]       rsp_valid;
   logic [AW-1:0]         rsp_addr;
   logic [DW-1:0]         rsp_data;
   logic                  rsp_err;

   spi_cmd_arbiter #(
      .NREQ        (NREQ),
      .AWIDTH      (AW),
      .DWIDTH      (DW),
      .TIMEOUT_CYC (TCYC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_cmd      (req_cmd),
      .req_ready    (req_ready),
      .master_en    (master_en),
      .driver_data  (driver_data),
      .driver_read  (driver_read),
      .xfer_done    (xfer_done),
      .spi_slv_addr (spi_slv_addr),
      .spi_slv_data (spi_slv_data),
      .rsp_valid    (rsp_valid),
      .rsp_addr     (rsp_addr),
      .rsp_data     (rsp_data),
      .rsp_err      (rsp_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: who won the previous completed transaction.
   int model_last;
   spi_cmd_t tcmd [NREQ];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int model_pick(input logic [NREQ-1:0] vec);
      for (int k = 1; k <= NREQ; k++) begin
         if (vec[(model_last + k) % NREQ]) return (model_last + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input int w);
      logic [NREQ-1:0] v;
      v = '0;
      v[w] = 1'b1;
      return v;
   endfunction

   task automatic fill_cmds();
      logic [63:0] r;
      for (int i = 0; i < NREQ; i++) begin
         r = {$urandom(), $urandom()};
         tcmd[i] = r[CMD_W-1:0];
      end
   endtask

   task automatic drive_cmds();
      for (int i = 0; i < NREQ; i++) req_cmd[i*CMD_W +: CMD_W] = tcmd[i];
   endtask

   task automatic scramble_slv();
      spi_slv_addr = AW'($urandom());
      spi_slv_data = DW'($urandom());
   endtask

   // One complete transaction, entered and left at a falling edge with the DUT idle.
   task automatic run_txn(input logic [NREQ-1:0] vec, input int rd_dly, input int done_dly,
                          input bit same, input logic [AW-1:0] ra, input logic [DW-1:0] rd);
      int w;
      w = model_pick(vec);
      drive_cmds();
      req_valid = vec;
      #1;
      check_eq("req_ready", req_ready, onehot(w));
      check_eq("master_en_idle", master_en, 0);
      @(negedge clk);
      req_valid = '0;
      for (int k = 0; k <= rd_dly; k++) begin
         check_eq("master_en_issue", master_en, 1);
         check_eq("driver_data", driver_data, tcmd[w]);
         check_eq("req_ready_busy", req_ready, 0);
         if (k == rd_dly) begin
            driver_read = 1'b1;
            if (same) begin
               xfer_done    = 1'b1;
               spi_slv_addr = ra;
               spi_slv_data = rd;
            end
         end
         @(negedge clk);
         driver_read = 1'b0;
         xfer_done   = 1'b0;
         scramble_slv();
      end
      if (!same) begin
         for (int k = 0; k <= done_dly; k++) begin
            check_eq("master_en_wait", master_en, 0);
            check_eq("rsp_valid_early", rsp_valid, 0);
            if (k == done_dly) begin
               xfer_done    = 1'b1;
               spi_slv_addr = ra;
               spi_slv_data = rd;
            end
            @(negedge clk);
            xfer_done = 1'b0;
            scramble_slv();
         end
      end
      check_eq("rsp_valid", rsp_valid, onehot(w));
      check_eq("rsp_addr", rsp_addr, ra);
      check_eq("rsp_data", rsp_data, rd);
      check_eq("rsp_err", rsp_err, 0);
      model_last = w;
      @(negedge clk);
      check_eq("rsp_valid_once", rsp_valid, 0);
      check_eq("rsp_data_hold", rsp_data, rd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst          = 1'b1;
      req_valid    = '1;
      req_cmd      = '1;
      driver_read  = 1'b0;
      xfer_done    = 1'b0;
      spi_slv_addr = '0;
      spi_slv_data = '0;
      model_last   = NREQ - 1;
      repeat (3) @(negedge clk);
      check_eq("rst_req_ready", req_ready, 0);
      check_eq("rst_master_en", master_en, 0);
      check_eq("rst_driver_data", driver_data, 0);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_rsp_addr", rsp_addr, 0);
      check_eq("rst_rsp_data", rsp_data, 0);
      check_eq("rst_rsp_err", rsp_err, 0);
      req_valid = '0;
      rst       = 1'b0;
      @(negedge clk);

      // Single write request from requester 0.
      fill_cmds();
      tcmd[0] = '{ss: 2'b01, wdata: 16'hA5A5, addr: 8'h12, size: 2'b01, wr_en: 1'b1};
      run_txn(3'b001, 2, 6, 1'b0, 8'h12, 16'hBEEF);

      // All requesters valid for six transactions.
      for (int i = 0; i < 6; i++) begin
         fill_cmds();
         run_txn(3'b111, i % 2, i % 3, 1'b0, AW'($urandom()), DW'($urandom()));
      end

      // Read return to requester 2.
      fill_cmds();
      tcmd[2] = '{ss: 2'b10, wdata: 16'h0000, addr: 8'h40, size: 2'b01, wr_en: 1'b0};
      run_txn(3'b100, 0, 3, 1'b0, 8'h40, 16'h1234);

      // driver_read and xfer_done together skip WAIT.
      fill_cmds();
      run_txn(3'b011, 1, 0, 1'b1, 8'h5A, 16'hC3C3);

      // Spurious pulses while idle.
      driver_read = 1'b1;
      xfer_done   = 1'b1;
      @(negedge clk);
      driver_read = 1'b0;
      xfer_done   = 1'b0;
      check_eq("spurious_rsp_valid", rsp_valid, 0);
      check_eq("spurious_master_en", master_en, 0);
      @(negedge clk);
      check_eq("spurious_rsp_valid2", rsp_valid, 0);

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         fill_cmds();
         run_txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(0, 4),
                 $urandom_range(0, 5), 1'(($urandom() & 3) == 0),
                 AW'($urandom()), DW'($urandom()));
      end

      // Reset while waiting for xfer_done.
      fill_cmds();
      run_txn(3'b001, 0, 1, 1'b0, 8'h77, 16'h7777);
      fill_cmds();
      drive_cmds();
      req_valid = 3'b001;
      @(negedge clk);
      req_valid   = '0;
      driver_read = 1'b1;
      @(negedge clk);
      driver_read = 1'b0;
      check_eq("mid_master_en_wait", master_en, 0);
      req_valid = 3'b011;
      rst       = 1'b1;
      #1;
      check_eq("mid_rst_master_en", master_en, 0);
      check_eq("mid_rst_req_ready", req_ready, 0);
      check_eq("mid_rst_rsp_valid", rsp_valid, 0);
      check_eq("mid_rst_rsp_data", rsp_data, 0);
      check_eq("mid_rst_rsp_addr", rsp_addr, 0);
      @(negedge clk);
      @(negedge clk);
      rst        = 1'b0;
      model_last = NREQ - 1;
      fill_cmds();
      run_txn(3'b111, 0, 0, 1'b0, 8'h01, 16'h0001);

`ifdef SPI_TIMEOUT_EN
      begin
         int w;
         fill_cmds();
         drive_cmds();
         req_valid = 3'b010;
         w = model_pick(3'b010);
         @(negedge clk);
         req_valid = '0;
         for (int k = 0; k < TCYC; k++) begin
            check_eq("tmo_master_en", master_en, 1);
            check_eq("tmo_rsp_valid_early", rsp_valid, 0);
            @(negedge clk);
         end
         check_eq("tmo_rsp_valid", rsp_valid, onehot(w));
         check_eq("tmo_rsp_err", rsp_err, 1);
         check_eq("tmo_rsp_data", rsp_data, 0);
         check_eq("tmo_master_en_drop", master_en, 0);
         model_last = w;
         xfer_done  = 1'b1;
         @(negedge clk);
         xfer_done = 1'b0;
         check_eq("tmo_late_done", rsp_valid, 0);
         @(negedge clk);
         check_eq("tmo_late_done2", rsp_valid, 0);
         fill_cmds();
         run_txn(3'b111, 0, 1, 1'b0, 8'h33, 16'h3333);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
